// File: rtl/ttt_pixel_renderer.sv
// TicTacToe pixel renderer: board grid, X/O marks, blinking cursor and win highlight.
// Three registered stages; hsync/vsync are delayed by the same three cycles.
module ttt_pixel_renderer #(
  parameter int BLINK_BIT = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [17:0] board,
  input  logic [3:0]  cursor,
  input  logic [8:0]  win_mask,
  output logic        hsync,
  output logic        vsync,
  output logic [2:0]  red,
  output logic [2:0]  green,
  output logic [1:0]  blue
);

  typedef enum logic [1:0] {
    MARK_NONE = 2'b00,
    MARK_X    = 2'b01,
    MARK_O    = 2'b10,
    MARK_RSVD = 2'b11
  } mark_t;

  // Frame latch state
  logic        r_vs_prev;
  logic [17:0] r_sh_board;
  logic [3:0]  r_sh_cursor;
  logic [8:0]  r_sh_win;
  logic [7:0]  r_frame_cnt;
  logic [1:0]  r_hs_dly;
  logic [1:0]  r_vs_dly;

  // Stage 1
  logic        r1_vis;
  logic        r1_inb;
  logic [3:0]  r1_cell;
  logic [7:0]  r1_lx;
  logic [7:0]  r1_ly;
  logic        r1_grid;

  // Stage 2
  logic        r2_show;
  logic        r2_grid;
  logic [1:0]  r2_mark;
  logic        r2_xhit;
  logic [14:0] r2_d2;
  logic        r2_cur;
  logic        r2_win;

  // Stage 0 geometry
  logic        w_vis;
  logic        w_inb;
  logic [10:0] w_rx;
  logic [1:0]  w_col;
  logic [1:0]  w_row;
  logic [7:0]  w_lx;
  logic [7:0]  w_ly;
  logic        w_gx;
  logic        w_gy;
  logic [3:0]  w_cell;
  logic        w_vs_fall;

  assign w_vis     = (hcount < 11'd800) && (vcount < 10'd600);
  assign w_inb     = (hcount >= 11'd100) && (hcount < 11'd700);
  assign w_rx      = hcount - 11'd100;
  assign w_gx      = ((w_rx >= 11'd198) && (w_rx <= 11'd201)) || ((w_rx >= 11'd398) && (w_rx <= 11'd401));
  assign w_gy      = ((vcount >= 10'd198) && (vcount <= 10'd201)) || ((vcount >= 10'd398) && (vcount <= 10'd401));
  assign w_cell    = {1'b0, w_row, 1'b0} + {2'b00, w_row} + {2'b00, w_col};
  assign w_vs_fall = r_vs_prev && !vsync_in;

  // Local offsets fit in 8 bits, so subtracting 200/400 modulo 256 is exact.
  always_comb begin
    w_col = 2'd0;
    w_lx  = w_rx[7:0];
    if (w_rx >= 11'd400) begin
      w_col = 2'd2;
      w_lx  = w_rx[7:0] - 8'd144;
    end else if (w_rx >= 11'd200) begin
      w_col = 2'd1;
      w_lx  = w_rx[7:0] - 8'd200;
    end
    w_row = 2'd0;
    w_ly  = vcount[7:0];
    if (vcount >= 10'd400) begin
      w_row = 2'd2;
      w_ly  = vcount[7:0] - 8'd144;
    end else if (vcount >= 10'd200) begin
      w_row = 2'd1;
      w_ly  = vcount[7:0] - 8'd200;
    end
  end

  // Stage 1 feature extraction
  logic [1:0]  w_mark;
  logic        w_win;
  logic        w_inx;
  logic [7:0]  w_dxy;
  logic [8:0]  w_sum;
  logic [8:0]  w_asum;
  logic        w_xhit;
  logic [6:0]  w_adx;
  logic [6:0]  w_ady;
  logic [14:0] w_d2;
  logic        w_band;
  logic        w_cur;

  always_comb begin
    w_mark = 2'b00;
    w_win  = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (r1_cell == 4'(i)) begin
        w_mark = r_sh_board[2*i +: 2];
        w_win  = r_sh_win[i];
      end
    end
  end

  assign w_inx  = (r1_lx >= 8'd30) && (r1_lx <= 8'd169) && (r1_ly >= 8'd30) && (r1_ly <= 8'd169);
  assign w_dxy  = (r1_lx >= r1_ly) ? (r1_lx - r1_ly) : (r1_ly - r1_lx);
  assign w_sum  = {1'b0, r1_lx} + {1'b0, r1_ly};
  assign w_asum = (w_sum >= 9'd199) ? (w_sum - 9'd199) : (9'd199 - w_sum);
  assign w_xhit = w_inx && ((w_dxy <= 8'd4) || (w_asum <= 9'd4));
  assign w_adx  = (r1_lx >= 8'd100) ? 7'(r1_lx - 8'd100) : 7'(8'd100 - r1_lx);
  assign w_ady  = (r1_ly >= 8'd100) ? 7'(r1_ly - 8'd100) : 7'(8'd100 - r1_ly);
  assign w_d2   = 15'(w_adx) * 15'(w_adx) + 15'(w_ady) * 15'(w_ady);
  assign w_band = (r1_lx < 8'd8) || (r1_lx > 8'd191) || (r1_ly < 8'd8) || (r1_ly > 8'd191);
  assign w_cur  = (r_sh_cursor == r1_cell) && !r_frame_cnt[BLINK_BIT] && w_band;

  // Shadow registers only move on the vsync falling edge, deep in vertical blanking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vs_prev   <= 1'b1;
      r_sh_board  <= 18'd0;
      r_sh_cursor <= 4'd15;
      r_sh_win    <= 9'd0;
      r_frame_cnt <= 8'd0;
    end else begin
      r_vs_prev <= vsync_in;
      if (w_vs_fall) begin
        r_sh_board  <= board;
        r_sh_cursor <= cursor;
        r_sh_win    <= win_mask;
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hs_dly <= 2'b11;
      r_vs_dly <= 2'b11;
      hsync    <= 1'b1;
      vsync    <= 1'b1;
    end else begin
      r_hs_dly <= {r_hs_dly[0], hsync_in};
      r_vs_dly <= {r_vs_dly[0], vsync_in};
      hsync    <= r_hs_dly[1];
      vsync    <= r_vs_dly[1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r1_vis  <= 1'b0;
      r1_inb  <= 1'b0;
      r1_cell <= 4'd0;
      r1_lx   <= 8'd0;
      r1_ly   <= 8'd0;
      r1_grid <= 1'b0;
    end else begin
      r1_vis  <= w_vis;
      r1_inb  <= w_inb;
      r1_cell <= w_cell;
      r1_lx   <= w_lx;
      r1_ly   <= w_ly;
      r1_grid <= w_gx || w_gy;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r2_show <= 1'b0;
      r2_grid <= 1'b0;
      r2_mark <= 2'b00;
      r2_xhit <= 1'b0;
      r2_d2   <= 15'd0;
      r2_cur  <= 1'b0;
      r2_win  <= 1'b0;
    end else begin
      r2_show <= r1_vis && r1_inb;
      r2_grid <= r1_grid;
      r2_mark <= w_mark;
      r2_xhit <= w_xhit;
      r2_d2   <= w_d2;
      r2_cur  <= w_cur;
      r2_win  <= w_win;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      red   <= 3'd0;
      green <= 3'd0;
      blue  <= 2'd0;
    end else if (!r2_show) begin
      {red, green, blue} <= 8'h00;
    end else if (r2_grid) begin
      {red, green, blue} <= {3'd7, 3'd7, 2'd3};
    end else if (r2_cur) begin
      {red, green, blue} <= {3'd7, 3'd7, 2'd0};
    end else if ((mark_t'(r2_mark) == MARK_X) && r2_xhit) begin
      {red, green, blue} <= {3'd7, 3'd0, 2'd0};
    end else if ((mark_t'(r2_mark) == MARK_O) && (r2_d2 >= 15'd3600) && (r2_d2 <= 15'd4900)) begin
      {red, green, blue} <= {3'd0, 3'd0, 2'd3};
    end else if (r2_win) begin
      {red, green, blue} <= {3'd0, 3'd3, 2'd0};
    end else begin
      {red, green, blue} <= 8'h00;
    end
  end

endmodule

// File: tb/tb_ttt_pixel_renderer.sv
// Scoreboard bench for ttt_pixel_renderer: stimulus pushes expected outputs, a monitor compares them.
module tb_ttt_pixel_renderer;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        hsync_in;
  logic        vsync_in;
  logic [17:0] board;
  logic [3:0]  cursor;
  logic [8:0]  win_mask;
  logic        hsync;
  logic        vsync;
  logic [2:0]  red;
  logic [2:0]  green;
  logic [1:0]  blue;

  always #5 clk = ~clk;

  ttt_pixel_renderer #(.BLINK_BIT(5)) dut (
    .clk(clk), .rst(rst), .hcount(hcount), .vcount(vcount),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .board(board), .cursor(cursor),
    .win_mask(win_mask), .hsync(hsync), .vsync(vsync),
    .red(red), .green(green), .blue(blue)
  );

  localparam logic [7:0] BLK = 8'h00;
  localparam logic [7:0] WHT = {3'd7, 3'd7, 2'd3};
  localparam logic [7:0] YEL = {3'd7, 3'd7, 2'd0};
  localparam logic [7:0] RED = {3'd7, 3'd0, 2'd0};
  localparam logic [7:0] BLU = {3'd0, 3'd0, 2'd3};
  localparam logic [7:0] GRN = {3'd0, 3'd3, 2'd0};

  typedef struct {
    int         t;
    logic [9:0] exp;
    string      nm;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  int   fc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [9:0] got, input logic [9:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got rgb=%h hs=%b vs=%b, expected rgb=%h hs=%b vs=%b",
               nm, cyc, got[9:2], got[1], got[0], exp[9:2], exp[1], exp[0]);
    end
  endtask

  task automatic push(input int t, input logic [7:0] rgb, input logic hs, input logic vs, input string nm);
    exp_t e;
    e.t   = t;
    e.exp = {rgb, hs, vs};
    e.nm  = nm;
    q.push_back(e);
  endtask

  // Present one pixel; its result is due three edges later.
  task automatic px(input int h, input int v, input logic hs, input logic vs,
                    input logic [7:0] rgb, input string nm);
    @(posedge clk);
    #1;
    hcount   = 11'(h);
    vcount   = 10'(v);
    hsync_in = hs;
    vsync_in = vs;
    push(cyc + 3, rgb, hs, vs, nm);
  endtask

  task automatic vpulse();
    px(900, 601, 1'b1, 1'b1, BLK, "vs_pre");
    px(900, 601, 1'b1, 1'b0, BLK, "vs_low");
    px(900, 601, 1'b1, 1'b1, BLK, "vs_post");
    fc++;
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      if (q[0].t == cyc) begin
        chk(q[0].nm, {red, green, blue, hsync, vsync}, q[0].exp);
        void'(q.pop_front());
      end else if (q[0].t < cyc) begin
        n_cmp++;
        n_bad++;
        $display("FAIL %s: result due at cyc %0d not compared, now cyc %0d", q[0].nm, q[0].t, cyc);
        void'(q.pop_front());
      end
    end
  end

  int         tgt[6] = '{31, 32, 63, 64, 255, 256};
  logic [7:0] tex[6] = '{YEL, BLK, BLK, YEL, BLK, YEL};

  initial begin
    rst = 1'b0; hcount = 11'd400; vcount = 10'd300;
    hsync_in = 1'b0; vsync_in = 1'b0;
    board = 18'd0; cursor = 4'd15; win_mask = 9'd0;
    repeat (3) @(posedge clk);
    @(negedge clk) chk("reset_hold", {red, green, blue, hsync, vsync}, {BLK, 2'b11});
    @(posedge clk);
    #1 hsync_in = 1'b1; vsync_in = 1'b1;
    @(negedge clk) chk("reset_hold2", {red, green, blue, hsync, vsync}, {BLK, 2'b11});

    // Release with a grid pixel already on the inputs.
    @(posedge clk);
    #1 hcount = 11'd298; vcount = 10'd50; rst = 1'b1;
    push(cyc,     BLK, 1'b1, 1'b1, "release_0");
    push(cyc + 1, BLK, 1'b1, 1'b1, "release_1");
    push(cyc + 2, BLK, 1'b1, 1'b1, "release_2");
    push(cyc + 3, WHT, 1'b1, 1'b1, "grid_latency");

    px(500, 399, 1'b1, 1'b1, WHT, "grid_rx400");
    px(99,  50,  1'b1, 1'b1, BLK, "left_of_board");
    px(700, 50,  1'b1, 1'b1, BLK, "right_of_board");
    px(150, 600, 1'b1, 1'b1, BLK, "below_visible");
    px(400, 100, 1'b1, 1'b1, BLK, "empty_cell");

    for (int h = 830; h <= 980; h++)
      px(h, 50, (h >= 840 && h <= 967) ? 1'b0 : 1'b1, 1'b1, BLK, "hsync_pulse");

    // X in cell 4, cursor on cell 8.
    board = 18'h00100; cursor = 4'd8;
    vpulse();
    px(400, 300, 1'b1, 1'b1, RED, "x_center");
    px(400, 310, 1'b1, 1'b1, BLK, "x_off_diag");
    px(400, 304, 1'b1, 1'b1, RED, "x_diag_edge4");
    px(400, 305, 1'b1, 1'b1, BLK, "x_diag_edge5");
    px(330, 369, 1'b1, 1'b1, RED, "x_anti_corner");
    px(329, 370, 1'b1, 1'b1, BLK, "x_out_of_box");

    // O in cell 0.
    board = 18'h00102;
    vpulse();
    px(265, 100, 1'b1, 1'b1, BLU, "o_ring_4225");
    px(200, 100, 1'b1, 1'b1, BLK, "o_center");
    px(260, 100, 1'b1, 1'b1, BLU, "o_inner_3600");
    px(259, 100, 1'b1, 1'b1, BLK, "o_inside_3481");
    px(270, 100, 1'b1, 1'b1, BLU, "o_outer_4900");
    px(271, 100, 1'b1, 1'b1, BLK, "o_outside_5041");

    win_mask = 9'h001;
    vpulse();
    px(200, 100, 1'b1, 1'b1, GRN, "win_background");
    px(265, 100, 1'b1, 1'b1, BLU, "win_ring_priority");
    px(400, 100, 1'b1, 1'b1, BLK, "win_other_cell");

    px(503, 403, 1'b1, 1'b1, YEL, "cursor_corner");
    px(600, 500, 1'b1, 1'b1, BLK, "cursor_interior");
    px(691, 500, 1'b1, 1'b1, BLK, "cursor_lx191");
    px(692, 500, 1'b1, 1'b1, YEL, "cursor_lx192");

    for (int k = 0; k < 6; k++) begin
      while (fc < tgt[k]) vpulse();
      px(503, 403, 1'b1, 1'b1, tex[k], $sformatf("blink_frame%0d", fc));
    end

    // Board change mid-frame must wait for the next vsync fall.
    px(400, 300, 1'b1, 1'b1, RED, "tear_before");
    board = 18'h001D2;
    px(600, 100, 1'b1, 1'b1, BLK, "tear_same_frame");
    px(200, 300, 1'b1, 1'b1, BLK, "tear_cell3_same");
    vpulse();
    px(600, 100, 1'b1, 1'b1, RED, "tear_next_frame");
    px(200, 300, 1'b1, 1'b1, BLK, "code11_no_x");
    px(265, 300, 1'b1, 1'b1, BLK, "code11_no_o");
    px(400, 300, 1'b1, 1'b1, RED, "x_kept");

    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d results never compared, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ttt_pixel_renderer.md
# ttt_pixel_renderer

Pixel renderer for the TicTacToe display. It sits directly downstream of the 800x600 @ 40 MHz VGA timing generator and consumes its hcount/vcount/hsync/vsync. It draws the 3x3 board, X/O marks, a blinking cursor and winning-cell highlight from game-state inputs. The 3-stage registered pipeline has matching sync delay, so its outputs drive the VGA pins directly.

## Interface
- BLINK_BIT, default 5: frame-counter bit that sets cursor blink, 32 frames on / 32 off.
- clk  in  1  40 MHz pixel clock
- rst  in  1  asynchronous, active-low reset
- hcount  in  11  horizontal position from the timing generator, 0..1055
- vcount  in  10  vertical position, 0..627
- hsync_in  in  1  hsync from the timing generator, active-low
- vsync_in  in  1  vsync from the timing generator, active-low
- board  in  18  cell i at bits [2i+1:2i]; 00 empty, 01 X, 10 O, 11 treated as empty; cell i = 3*row+col
- cursor  in  4  selected cell 0..8; values 9..15 mean no cursor
- win_mask  in  9  bit i set = cell i is part of the winning line
- hsync  out  1  hsync_in delayed 3 cycles
- vsync  out  1  vsync_in delayed 3 cycles
- red  out  3  pixel colour
- green  out  3  pixel colour
- blue  out  2  pixel colour

## Operation
- **Frame latch**
  - On each vsync_in falling edge (registered previous value = 1, current = 0), copy board, cursor and win_mask into shadow registers.
  - Increment the 8-bit frame counter on the same edge; it wraps 255->0.
  - All drawing uses shadow values only, so a frame never tears.
- **Geometry**
  - Visible when hcount<800 and vcount<600.
  - Board region: 100<=hcount<700. rx = hcount-100, ry = vcount.
  - col/row = 0,1,2 for rx/ry in [0,199], [200,399], [400,599].
  - Local coordinates: lx = rx-200*col, ly = ry-200*row. Use comparisons and subtraction; no divider.
- **Pixel classes**, in priority order (first match wins):
  1. Not visible, or outside the board region: black 0,0,0.
  2. Grid: rx or ry in [198,201] or [398,401]: white 7,7,3.
  3. Cursor: shadow cursor == cell, blink on, and lx<8 or lx>191 or ly<8 or ly>191: yellow 7,7,0.
  4. X mark (cell code 01): 30<=lx,ly<=169 and (|lx-ly|<=4 or |lx+ly-199|<=4): red 7,0,0.
  5. O mark (cell code 10): dx=lx-100, dy=ly-100, d2=dx*dx+dy*dy (unsigned, 15 bits); 3600<=d2<=4900: blue 0,0,3.
  6. Win background: win_mask bit of the cell set: green 0,3,0.
  7. Otherwise black.
- **Blink**: on when frame_cnt[BLINK_BIT]==0.
- **Reset values** (rst low, asynchronous):
  - Colour outputs 0.
  - hsync, vsync, and all sync delay stages 1.
  - Pipeline valid/visible flags 0.
  - Shadow board 0 (all empty), shadow cursor 15, shadow win_mask 0.
  - frame_cnt 0, so blink is on immediately after reset.
  - Previous-vsync register 1.

## Timing
- **Stage 1**: register visible flag, in-board flag, cell index, lx, ly, grid flag.
- **Stage 2**: register mark type, X-hit, dx*dx+dy*dy, cursor-band flag, win flag.
- **Stage 3**: priority mux into the colour output registers.
- **Latency**: the inputs at edge N appear on red/green/blue/hsync/vsync after edge N+3; sync and colour stay aligned at every cycle.
- **Shadow update timing**: shadow registers update on the clock edge that detects the vsync falling edge.
  - Pixels already in the pipeline are unaffected; they are all blanking at vcount 601.
  - Game-input changes during a frame take effect at the next vsync falling edge.
- **Reset mid-frame**: outputs go to reset values immediately. After release, the pipeline refills in 3 cycles and the first 3 colour outputs are black.
- **Input assumptions**: the timing generator never presents hcount>1055 or vcount>627. Out-of-range values render black and are not an error.

## Test plan
- **Reset**: hold rst low with hcount=400, vcount=300 -> red/green/blue=0 and hsync=vsync=1; after release, the first 3 cycles output black.
- **Latency and grid**: board=0, present hcount=298, vcount=50 at cycle N -> output 7,7,3 at cycle N+3. A hsync_in low pulse on hcount 840..967 appears on hsync 3 cycles later with the same width (128).
- **X mark**: board cell 4=01, vsync edge, then hcount=400, vcount=300 -> 7,0,0. Then hcount=400, vcount=310 (lx=100, ly=110) -> black.
- **O ring**: cell 0=10; hcount=265, vcount=100 (d2=4225) -> 0,0,3. hcount=200, vcount=100 (d2=0) -> black. With win_mask bit 0 set, the d2=0 pixel -> 0,3,0.
- **Cursor blink**: cursor=8 after reset; hcount=503, vcount=403 -> 7,7,0 for frames 0..31 and black for frames 32..63. Frame counter wraps after 256 frames.
- **Tear-free latch**: change board cell 2 to 01 at vcount=300 -> the rest of that frame shows it empty; it appears only after the next vsync falling edge.
